// File: rtl/dcache_pkg.sv
//------------------------------------------------------------------------------
// Module  : dcache_pkg
// Brief   : Shared geometry constants and enums for the dcache data path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 128;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_CORE = 1'b0,
    OWN_FILL = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/dcache_data_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : dcache_data_arbiter_if
// Brief   : Core, fill and SRAM macro signals of the dcache data arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dcache_data_arbiter_if #(
  parameter int ADDR_WIDTH = dcache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dcache_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = dcache_pkg::NUM_WMASKS
);

  logic                  core_req_valid;
  logic                  core_req_ready;
  logic                  core_req_we;
  logic [ADDR_WIDTH-1:0] core_req_addr;
  logic [NUM_WMASKS-1:0] core_req_wmask;
  logic [DATA_WIDTH-1:0] core_req_wdata;
  logic                  core_resp_valid;
  logic [DATA_WIDTH-1:0] core_resp_rdata;

  logic                  fill_req_valid;
  logic                  fill_req_ready;
  logic                  fill_req_we;
  logic [ADDR_WIDTH-1:0] fill_req_addr;
  logic [DATA_WIDTH-1:0] fill_req_wdata;
  logic                  fill_resp_valid;
  logic [DATA_WIDTH-1:0] fill_resp_rdata;

  logic                  sram_csb;
  logic                  sram_web;
  logic [NUM_WMASKS-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  // Requester side, which also hosts the macro model
  modport master (
    output core_req_valid, core_req_we, core_req_addr, core_req_wmask, core_req_wdata,
    input  core_req_ready, core_resp_valid, core_resp_rdata,
    output fill_req_valid, fill_req_we, fill_req_addr, fill_req_wdata,
    input  fill_req_ready, fill_resp_valid, fill_resp_rdata,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );

  modport slave (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wmask, core_req_wdata,
    output core_req_ready, core_resp_valid, core_resp_rdata,
    input  fill_req_valid, fill_req_we, fill_req_addr, fill_req_wdata,
    output fill_req_ready, fill_resp_valid, fill_resp_rdata,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

endinterface

`default_nettype wire

// File: rtl/dcache_data_arbiter.sv
//------------------------------------------------------------------------------
// Module  : dcache_data_arbiter
// Brief   : Single-port dcache SRAM access arbiter (fill-priority, core anti-starvation).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcache_data_arbiter #(
  parameter int ADDR_WIDTH = dcache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dcache_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = dcache_pkg::NUM_WMASKS,
  parameter int MAX_STALL  = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  dcache_data_arbiter_if.slave    bus
);

  import dcache_pkg::*;

  localparam int                 STALL_W   = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  state_t               r_state;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 r_tag_valid;
  owner_t               r_tag_owner;

  logic                  w_run;
  logic                  w_starve;
  logic                  w_core_gnt;
  logic                  w_fill_gnt;
  logic                  w_rd_accept;
  logic                  w_csb;
  logic                  w_web;
  logic [NUM_WMASKS-1:0] w_wmask;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;

  assign w_run      = (r_state == RUN);
  assign w_starve   = (r_stall_cnt == STALL_MAX);
  assign w_core_gnt = w_run && bus.core_req_valid && (!bus.fill_req_valid || w_starve);
  assign w_fill_gnt = w_run && bus.fill_req_valid && !w_core_gnt;
  assign w_rd_accept = (w_core_gnt && !bus.core_req_we) || (w_fill_gnt && !bus.fill_req_we);

  assign bus.core_req_ready = w_core_gnt;
  assign bus.fill_req_ready = w_fill_gnt;

  always_comb begin
    w_csb   = 1'b1;
    w_web   = 1'b1;
    w_wmask = '0;
    w_addr  = '0;
    w_din   = '0;
    if (w_core_gnt) begin
      w_csb  = 1'b0;
      w_web  = !bus.core_req_we;
      w_addr = bus.core_req_addr;
      if (bus.core_req_we) begin
        w_wmask = bus.core_req_wmask;
        w_din   = bus.core_req_wdata;
      end
    end else if (w_fill_gnt) begin
      w_csb  = 1'b0;
      w_web  = !bus.fill_req_we;
      w_addr = bus.fill_req_addr;
      if (bus.fill_req_we) begin
        w_wmask = '1;
        w_din   = bus.fill_req_wdata;
      end
    end else if ((r_state == INIT) && rst_n) begin
      // Dummy read so the macro's write-enable register leaves reset defined
      w_csb = 1'b0;
    end
  end

  assign bus.sram_csb   = w_csb;
  assign bus.sram_web   = w_web;
  assign bus.sram_wmask = w_wmask;
  assign bus.sram_addr  = w_addr;
  assign bus.sram_din   = w_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT;
      r_stall_cnt <= '0;
      r_tag_valid <= 1'b0;
      r_tag_owner <= OWN_CORE;
    end else begin
      case (r_state)
        INIT:    r_state <= RUN;
        RUN:     r_state <= RUN;
        default: r_state <= INIT;
      endcase

      if (!bus.core_req_valid || w_core_gnt) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != STALL_MAX) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      r_tag_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_tag_owner <= w_fill_gnt ? OWN_FILL : OWN_CORE;
      end
    end
  end

  // Macro output is forwarded straight to whichever port owns the pending read
  assign bus.core_resp_valid = r_tag_valid && (r_tag_owner == OWN_CORE);
  assign bus.fill_resp_valid = r_tag_valid && (r_tag_owner == OWN_FILL);
  assign bus.core_resp_rdata = bus.core_resp_valid ? bus.sram_dout : '0;
  assign bus.fill_resp_rdata = bus.fill_resp_valid ? bus.sram_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_dcache_data_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_dcache_data_arbiter
// Brief   : Directed scoreboard bench for dcache_data_arbiter with a behavioural macro.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dcache_data_arbiter;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  dcache_data_arbiter_if ifc ();

  dcache_data_arbiter #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (128),
    .NUM_WMASKS (16),
    .MAX_STALL  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] init_line(input int i);
    logic [7:0] b;
    b = 8'(i * 17);
    return {16{b}};
  endfunction

  // Behavioural macro: inputs sampled on the rising edge, dout registered
  logic [127:0] mem [16];
  logic         mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_line(i);
      mem_loaded <= 1'b1;
    end else if (!ifc.sram_csb) begin
      if (!ifc.sram_web) begin
        for (int b = 0; b < 16; b++)
          if (ifc.sram_wmask[b]) mem[ifc.sram_addr][b*8 +: 8] <= ifc.sram_din[b*8 +: 8];
      end else begin
        ifc.sram_dout <= mem[ifc.sram_addr];
      end
    end
  end

  typedef struct {
    bit           is_fill;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  logic [127:0] ref_mem [16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_init();
    chk("init_csb", ifc.sram_csb, 0);
    chk("init_web", ifc.sram_web, 1);
    chk("init_addr", ifc.sram_addr, 0);
    chk("init_core_ready", ifc.core_req_ready, 0);
    chk("init_fill_ready", ifc.fill_req_ready, 0);
    chk("init_resp", ifc.core_resp_valid | ifc.fill_resp_valid, 0);
  endtask

  // One cycle: check grants and macro drive at negedge, log expectations, advance
  task automatic tick(input bit exp_c, input bit exp_f, input bit push = 1'b1);
    logic [3:0] a;
    @(negedge clk);
    chk("core_ready", ifc.core_req_ready, exp_c);
    chk("fill_ready", ifc.fill_req_ready, exp_f);
    if (exp_c) begin
      a = ifc.core_req_addr;
      chk("csb_core", ifc.sram_csb, 0);
      chk("addr_core", ifc.sram_addr, a);
      chk("web_core", ifc.sram_web, !ifc.core_req_we);
      if (ifc.core_req_we) begin
        chk("wmask_core", ifc.sram_wmask, ifc.core_req_wmask);
        chk("din_core", ifc.sram_din, ifc.core_req_wdata);
        for (int b = 0; b < 16; b++)
          if (ifc.core_req_wmask[b]) ref_mem[a][b*8 +: 8] = ifc.core_req_wdata[b*8 +: 8];
      end else begin
        chk("wmask_core_rd", ifc.sram_wmask, 0);
        if (push) q.push_back('{1'b0, ref_mem[a], cyc + 1});
      end
    end else if (exp_f) begin
      a = ifc.fill_req_addr;
      chk("csb_fill", ifc.sram_csb, 0);
      chk("addr_fill", ifc.sram_addr, a);
      chk("web_fill", ifc.sram_web, !ifc.fill_req_we);
      if (ifc.fill_req_we) begin
        chk("wmask_fill", ifc.sram_wmask, 16'hFFFF);
        chk("din_fill", ifc.sram_din, ifc.fill_req_wdata);
        ref_mem[a] = ifc.fill_req_wdata;
      end else begin
        chk("wmask_fill_rd", ifc.sram_wmask, 0);
        if (push) q.push_back('{1'b1, ref_mem[a], cyc + 1});
      end
    end else begin
      chk("csb_idle", ifc.sram_csb, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic core_drive(input bit v, input bit we, input logic [3:0] a,
                            input logic [15:0] m, input logic [127:0] d);
    ifc.core_req_valid = v;
    ifc.core_req_we    = we;
    ifc.core_req_addr  = a;
    ifc.core_req_wmask = m;
    ifc.core_req_wdata = d;
  endtask

  task automatic fill_drive(input bit v, input bit we, input logic [3:0] a, input logic [127:0] d);
    ifc.fill_req_valid = v;
    ifc.fill_req_we    = we;
    ifc.fill_req_addr  = a;
    ifc.fill_req_wdata = d;
  endtask

  // Monitor: pops one expectation per response and flags late or stray responses
  always @(negedge clk) begin
    if (ifc.core_resp_valid || ifc.fill_resp_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL resp_unexpected: core_v=%0b fill_v=%0b, expected none (cycle %0d)",
                 ifc.core_resp_valid, ifc.fill_resp_valid, cyc);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.due);
        chk("resp_owner_fill", ifc.fill_resp_valid, e.is_fill);
        chk("resp_owner_core", ifc.core_resp_valid, !e.is_fill);
        if (e.is_fill) begin
          chk("fill_rdata", ifc.fill_resp_rdata, e.data);
          chk("core_rdata_zero", ifc.core_resp_rdata, 0);
        end else begin
          chk("core_rdata", ifc.core_resp_rdata, e.data);
          chk("fill_rdata_zero", ifc.fill_resp_rdata, 0);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL resp_missing: got no resp_valid, expected fill=%0b data %0h (cycle %0d)",
               e.is_fill, e.data, cyc);
    end
  end

  initial begin
    rst_n = 1'b0;
    ifc.sram_dout = '0;
    core_drive(0, 0, 0, 0, 0);
    fill_drive(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = init_line(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_ready", ifc.core_req_ready, 0);
    chk("rst_fill_ready", ifc.fill_req_ready, 0);
    chk("rst_resp", ifc.core_resp_valid | ifc.fill_resp_valid, 0);
    chk("rst_csb", ifc.sram_csb, 1);
    chk("rst_web", ifc.sram_web, 1);
    chk("rst_wmask", ifc.sram_wmask, 0);
    chk("rst_addr", ifc.sram_addr, 0);
    chk("rst_din", ifc.sram_din, 0);

    // Release: INIT cycle ignores a pending core read, which wins next cycle
    rst_n = 1'b1;
    core_drive(1, 0, 4'd3, 0, 0);
    #1 chk_init();
    @(posedge clk);
    #1;
    tick(1, 0);
    core_drive(0, 0, 0, 0, 0);

    // Partial-mask write followed immediately by a read of the same line
    core_drive(1, 1, 4'd5, 16'h0003, {112'h1234_5678_9ABC_DEF0_1122_3344_5566, 16'hBEEF});
    tick(1, 0);
    core_drive(1, 0, 4'd5, 0, 0);
    tick(1, 0);

    // Zero-mask write leaves the line intact
    core_drive(1, 1, 4'd6, 16'h0000, {128{1'b1}});
    tick(1, 0);
    core_drive(1, 0, 4'd6, 0, 0);
    tick(1, 0);
    core_drive(0, 0, 0, 0, 0);

    // Fill refill beats a simultaneous core read of the same line
    fill_drive(1, 1, 4'd2, 128'hF00D_CAFE_0123_4567_89AB_CDEF_0F1E_2D3C);
    core_drive(1, 0, 4'd2, 0, 0);
    tick(0, 1);
    fill_drive(0, 0, 0, 0);
    tick(1, 0);
    core_drive(0, 0, 0, 0, 0);

    // Continuous fill traffic: core denied four cycles, then forced through
    fill_drive(1, 1, 4'd10, 128'hAAAA_5555_AAAA_5555_1357_9BDF_2468_ACE0);
    core_drive(1, 0, 4'd7, 0, 0);
    repeat (4) tick(0, 1);
    tick(1, 0);
    core_drive(0, 0, 0, 0, 0);
    tick(0, 1);
    fill_drive(0, 0, 0, 0);

    // Writeback read goes to the fill response port only
    fill_drive(1, 0, 4'd9, 0);
    tick(0, 1);
    fill_drive(0, 0, 0, 0);
    core_drive(1, 0, 4'd10, 0, 0);
    tick(1, 0);
    core_drive(0, 0, 0, 0, 0);
    tick(0, 0);

    // Reset right after a read grant drops the response and reruns INIT
    core_drive(1, 0, 4'd4, 0, 0);
    tick(1, 0, 1'b0);
    rst_n = 1'b0;
    core_drive(0, 0, 0, 0, 0);
    #1;
    chk("midrst_core_resp", ifc.core_resp_valid, 0);
    chk("midrst_fill_resp", ifc.fill_resp_valid, 0);
    chk("midrst_csb", ifc.sram_csb, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_init();
    @(posedge clk);
    #1;
    core_drive(1, 0, 4'd4, 0, 0);
    tick(1, 0);
    core_drive(0, 0, 0, 0, 0);
    tick(0, 0);
    tick(0, 0);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
